// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types for the memory arbiter: FSM state encoding and the
//   arbitration mode selectors used by the ARB_MODE parameter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick
//   Combinational picker: finds the first set request bit at or after
//   index 'start', wrapping from N-1 back to 0.
//   req   in  N   request vector
//   start in  IW  search start index (0 gives plain lowest-index priority)
//   gnt   out N   one-hot grant, zero when nothing requested
//   idx   out IW  index of the granted bit
//   vld   out 1   any request present
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  always_comb begin : pick
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(start) + i;
      if (j >= N) j = j - N;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one word-wide RAM port between NUM_CH requesters. A winning
//   request is latched in IDLE, driven to the RAM in ACCESS until busy_o
//   drops (or the optional timeout expires), and completed with a one-cycle
//   ready (plus error on timeout) in RESP.
//   CLK, RST            clock / async active-high reset
//   ch_req/ch_wen       per-channel request and direction
//   ch_addr/ch_wdata    packed per-channel address / write data
//   ch_rdata            last read data returned
//   ch_ready/ch_err     one-hot completion / timeout pulses
//   Ren/Wen/ramaddr/ramstore/ramload/busy_o   RAM port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_wen,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [NUM_CH-1:0]        ch_err,
  output logic                     Ren,
  output logic                     Wen,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [DATA_W-1:0]        ramstore,
  input  logic [DATA_W-1:0]        ramload,
  input  logic                     busy_o
);

  localparam int IW = $clog2(NUM_CH);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Abort fires on the edge that closes the TIMEOUT-th ACCESS cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t state, state_nxt;

  logic [NUM_CH-1:0] pick_gnt, gnt_q;
  logic [IW-1:0]     pick_idx, ptr, start;
  logic              pick_vld;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              wen_q, err_q;
  logic [CW-1:0]     cnt;
  logic              timeout_hit;

  assign start = (ARB_MODE == ARB_RR) ? ptr : '0;

  rr_pick #(.N(NUM_CH), .IW(IW)) u_pick (
    .req   (ch_req),
    .start (start),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .vld   (pick_vld)
  );

  assign timeout_hit = (TIMEOUT > 0) && (state == ACCESS) && busy_o && (cnt == CNT_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = ACCESS;
      ACCESS:  if (!busy_o || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM strobes come straight from state so an async reset drops them at once.
  always_comb begin
    Ren      = 1'b0;
    Wen      = 1'b0;
    ch_ready = '0;
    ch_err   = '0;
    case (state)
      ACCESS: begin
        Ren = ~wen_q;
        Wen = wen_q;
      end
      RESP: begin
        ch_ready = gnt_q;
        if (err_q) ch_err = gnt_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wen_q   <= 1'b0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
      ptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            addr_q  <= ch_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            wdata_q <= ch_wdata[int'(pick_idx)*DATA_W +: DATA_W];
            wen_q   <= ch_wen[pick_idx];
            gnt_q   <= pick_gnt;
            err_q   <= 1'b0;
            cnt     <= '0;
            if (pick_idx == IW'(NUM_CH - 1)) ptr <= '0;
            else                             ptr <= pick_idx + 1'b1;
          end
        end
        ACCESS: begin
          if (!busy_o) begin
            if (!wen_q) rdata_q <= ramload;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ramaddr  = addr_q;
  assign ramstore = wdata_q;
  assign ch_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- DUT A: 2 channels, fixed priority, no timeout
  logic        rst_fx;
  logic [1:0]  req_a, wenv_a, ready_a, err_a;
  logic [63:0] addr_a, wdata_a;
  logic [31:0] rdata_a, ramaddr_a, ramstore_a, ramload_a;
  logic        ren_a, wen_a, busy_a;

  mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(0)) u_fix (
    .CLK(clk), .RST(rst_fx), .ch_req(req_a), .ch_wen(wenv_a), .ch_addr(addr_a),
    .ch_wdata(wdata_a), .ch_rdata(rdata_a), .ch_ready(ready_a), .ch_err(err_a),
    .Ren(ren_a), .Wen(wen_a), .ramaddr(ramaddr_a), .ramstore(ramstore_a),
    .ramload(ramload_a), .busy_o(busy_a)
  );

  // ---------------- DUT B: 4 channels, round-robin, TIMEOUT=8
  logic         rst_rr;
  logic [3:0]   req_b, wenv_b, ready_b, err_b;
  logic [127:0] addr_b, wdata_b;
  logic [31:0]  rdata_b, ramaddr_b, ramstore_b, ramload_b;
  logic         ren_b, wen_b, busy_b;

  mem_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(8)) u_rr (
    .CLK(clk), .RST(rst_rr), .ch_req(req_b), .ch_wen(wenv_b), .ch_addr(addr_b),
    .ch_wdata(wdata_b), .ch_rdata(rdata_b), .ch_ready(ready_b), .ch_err(err_b),
    .Ren(ren_b), .Wen(wen_b), .ramaddr(ramaddr_b), .ramstore(ramstore_b),
    .ramload(ramload_b), .busy_o(busy_b)
  );

  typedef struct {
    int          ch;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wen;
    logic [31:0] addr0, addr1, wd0, wd1;
    int          busy;
  } vec_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  logic [31:0] mem_a    [logic [31:0]];
  logic [31:0] expmem_a [logic [31:0]];

  int busy_cfg_a = 0, acc_a = 0, tick_no_a = 0, wen_cyc_a = 0, ren_cyc_a = 0, rdy_tick_a = 0;
  int busy_cfg_b = 0, acc_b = 0, tick_no_b = 0, ren_cyc_b = 0, rdy_tick_b = 0;
  logic [31:0] exp_rd_a = 0, exp_rd_b = 0;
  bit hold_b = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  function automatic logic [31:0] ram_rd_a(input logic [31:0] a);
    if (mem_a.exists(a)) return mem_a[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] rr_load(input logic [31:0] a);
    return 32'h5A00_0000 ^ a;
  endfunction

  task automatic push_a(input int ch, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.ch = ch; e.wen = w; e.addr = a; e.wdata = d; e.err = 1'b0;
    if (w) begin
      expmem_a[a] = d;
      e.rdata = exp_rd_a;
    end else begin
      e.rdata  = expmem_a.exists(a) ? expmem_a[a] : dflt(a);
      exp_rd_a = e.rdata;
    end
    sb_a.push_back(e);
  endtask

  task automatic push_b(input int ch, input logic [31:0] a, input logic timed_out);
    exp_t e;
    e.ch = ch; e.wen = 1'b0; e.addr = a; e.wdata = '0; e.err = timed_out;
    if (timed_out) e.rdata = exp_rd_b;
    else begin
      e.rdata  = rr_load(a);
      exp_rd_b = e.rdata;
    end
    sb_b.push_back(e);
  endtask

  // One cycle for DUT A: sample at negedge, run RAM model, retire ready.
  task automatic tick_a();
    exp_t e;
    logic exp_ren;
    @(negedge clk);
    tick_no_a++;
    if (ren_a || wen_a) begin
      acc_a++;
      if (wen_a) wen_cyc_a++;
      if (ren_a) ren_cyc_a++;
      if (sb_a.size() > 0) begin
        exp_ren = !sb_a[0].wen;
        chk("a_ramaddr", ramaddr_a, sb_a[0].addr);
        chk("a_wen", wen_a, sb_a[0].wen);
        chk("a_ren", ren_a, exp_ren);
        if (sb_a[0].wen) chk("a_ramstore", ramstore_a, sb_a[0].wdata);
      end else begin
        chk("a_access_unexpected", {ren_a, wen_a}, 0);
      end
      busy_a = (acc_a <= busy_cfg_a);
      if (wen_a && !busy_a) mem_a[ramaddr_a] = ramstore_a;
    end else begin
      acc_a  = 0;
      busy_a = 1'b0;
    end
    ramload_a = ram_rd_a(ramaddr_a);
    if (ready_a != 0) begin
      rdy_tick_a = tick_no_a;
      if (sb_a.size() == 0) chk("a_ready_unexpected", ready_a, 0);
      else begin
        e = sb_a.pop_front();
        chk("a_ready", ready_a, 1 << e.ch);
        chk("a_rdata", rdata_a, e.rdata);
        chk("a_err", err_a, 0);
        req_a[e.ch] = 1'b0;
      end
    end
  endtask

  task automatic tick_b();
    exp_t e;
    @(negedge clk);
    tick_no_b++;
    if (ren_b || wen_b) begin
      acc_b++;
      if (ren_b) ren_cyc_b++;
      if (sb_b.size() > 0) begin
        chk("b_ramaddr", ramaddr_b, sb_b[0].addr);
        chk("b_ren", {ren_b, wen_b}, 2'b10);
      end else begin
        chk("b_access_unexpected", {ren_b, wen_b}, 0);
      end
      busy_b = (acc_b <= busy_cfg_b);
    end else begin
      acc_b  = 0;
      busy_b = 1'b0;
    end
    ramload_b = rr_load(ramaddr_b);
    if (ready_b != 0) begin
      rdy_tick_b = tick_no_b;
      if (sb_b.size() == 0) chk("b_ready_unexpected", ready_b, 0);
      else begin
        e = sb_b.pop_front();
        chk("b_ready", ready_b, 1 << e.ch);
        chk("b_rdata", rdata_b, e.rdata);
        chk("b_err", err_b, e.err ? (1 << e.ch) : 0);
        if (!hold_b) req_b[e.ch] = 1'b0;
      end
    end
  endtask

  task automatic drain_a(input string name);
    for (int n = 0; n < 100 && sb_a.size() > 0; n++) tick_a();
    if (sb_a.size() > 0) begin
      chk({name, "_pending"}, sb_a.size(), 0);
      sb_a.delete();
      req_a = '0;
    end
  endtask

  task automatic drain_b(input string name);
    for (int n = 0; n < 100 && sb_b.size() > 0; n++) tick_b();
    if (sb_b.size() > 0) begin
      chk({name, "_pending"}, sb_b.size(), 0);
      sb_b.delete();
    end
    req_b = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t vecs[6];
  int   order[5];

  initial begin
    vecs[0] = '{req:2'b11, wen:2'b00, addr0:32'h100, addr1:32'h200, wd0:32'h0, wd1:32'h0, busy:0};
    vecs[1] = '{req:2'b10, wen:2'b10, addr0:32'h000, addr1:32'h080, wd0:32'h0, wd1:32'h12345678, busy:1};
    vecs[2] = '{req:2'b11, wen:2'b01, addr0:32'h300, addr1:32'h080, wd0:32'hCAFEF00D, wd1:32'h0, busy:2};
    vecs[3] = '{req:2'b01, wen:2'b00, addr0:32'h300, addr1:32'h000, wd0:32'h0, wd1:32'h0, busy:0};
    vecs[4] = '{req:2'b11, wen:2'b11, addr0:32'h010, addr1:32'h014, wd0:32'h11111111, wd1:32'h22222222, busy:1};
    vecs[5] = '{req:2'b10, wen:2'b00, addr0:32'h000, addr1:32'h014, wd0:32'h0, wd1:32'h0, busy:2};

    rst_fx = 1'b1; rst_rr = 1'b1;
    req_a = '0; wenv_a = '0; addr_a = '0; wdata_a = '0; ramload_a = '0; busy_a = 1'b0;
    req_b = '0; wenv_b = '0; wdata_b = '0; ramload_b = '0; busy_b = 1'b0;
    addr_b = {32'h400, 32'h300, 32'h200, 32'h100};
    repeat (2) @(negedge clk);
    chk("rst_a_ren", ren_a, 0);
    chk("rst_a_wen", wen_a, 0);
    chk("rst_a_ramaddr", ramaddr_a, 0);
    chk("rst_a_ramstore", ramstore_a, 0);
    chk("rst_a_rdata", rdata_a, 0);
    chk("rst_a_ready", ready_a, 0);
    chk("rst_a_err", err_a, 0);
    chk("rst_b_ren", ren_b, 0);
    chk("rst_b_ready", ready_b, 0);
    chk("rst_b_rdata", rdata_b, 0);
    rst_fx = 1'b0; rst_rr = 1'b0;
    tick_a();

    // Table-driven fixed-priority transactions (ch0 outranks ch1).
    for (int v = 0; v < 6; v++) begin
      busy_cfg_a = vecs[v].busy;
      wenv_a     = vecs[v].wen;
      addr_a     = {vecs[v].addr1, vecs[v].addr0};
      wdata_a    = {vecs[v].wd1, vecs[v].wd0};
      if (vecs[v].req[0]) push_a(0, vecs[v].wen[0], vecs[v].addr0, vecs[v].wd0);
      if (vecs[v].req[1]) push_a(1, vecs[v].wen[1], vecs[v].addr1, vecs[v].wd1);
      req_a = vecs[v].req;
      drain_a("vec");
      tick_a();
    end

    // Write with busy high for 3 cycles, then read back.
    busy_cfg_a = 3; wenv_a = 2'b01;
    addr_a = {32'h0, 32'h40}; wdata_a = {32'h0, 32'hDEADBEEF};
    push_a(0, 1'b1, 32'h40, 32'hDEADBEEF);
    tick_no_a = 0; wen_cyc_a = 0; rdy_tick_a = 0;
    req_a = 2'b01;
    drain_a("wr");
    chk("wr_wen_cycles", wen_cyc_a, 4);
    chk("wr_ready_tick", rdy_tick_a, 5);
    tick_a();
    busy_cfg_a = 0; wenv_a = 2'b00;
    push_a(0, 1'b0, 32'h40, 32'h0);
    tick_no_a = 0; ren_cyc_a = 0; rdy_tick_a = 0;
    req_a = 2'b01;
    drain_a("rdback");
    chk("rdback_ready_tick", rdy_tick_a, 2);
    chk("rdback_ren_cycles", ren_cyc_a, 1);
    chk("rdback_rdata", rdata_a, 32'hDEADBEEF);
    tick_a();

    // Address and direction changed after grant must not reach the RAM.
    busy_cfg_a = 2; wenv_a = 2'b00; addr_a = {32'h0, 32'h10};
    push_a(0, 1'b0, 32'h10, 32'h0);
    req_a = 2'b01;
    tick_a();
    chk("late_change_in_access", ren_a, 1);
    addr_a = {32'h0, 32'h20}; wenv_a = 2'b01;
    drain_a("late");
    wenv_a = 2'b00;
    tick_a();

    // Reset in the middle of an access.
    busy_cfg_a = 5; addr_a = {32'h0, 32'h44};
    push_a(0, 1'b0, 32'h44, 32'h0);
    req_a = 2'b01;
    tick_a();
    tick_a();
    chk("mid_rst_pre_ren", ren_a, 1);
    #2 rst_fx = 1'b1;
    #1;
    chk("mid_rst_ren", ren_a, 0);
    chk("mid_rst_wen", wen_a, 0);
    chk("mid_rst_ramaddr", ramaddr_a, 0);
    chk("mid_rst_rdata", rdata_a, 0);
    sb_a.delete();
    req_a = '0;
    exp_rd_a = '0;
    tick_a();
    tick_a();
    rst_fx = 1'b0;
    tick_a();
    busy_cfg_a = 0;
    push_a(0, 1'b0, 32'h44, 32'h0);
    tick_no_a = 0; rdy_tick_a = 0;
    req_a = 2'b01;
    drain_a("post_rst");
    chk("post_rst_ready_tick", rdy_tick_a, 2);
    tick_a();

    // Round-robin with every channel held: 0,1,2,3,0.
    order = '{0, 1, 2, 3, 0};
    hold_b = 1; busy_cfg_b = 0;
    foreach (order[i]) push_b(order[i], addr_b[order[i]*32 +: 32], 1'b0);
    req_b = 4'hF;
    drain_b("rr_all");
    tick_b(); tick_b();

    // Pointer now at 1; only ch0 and ch3 request -> 3,0,3.
    push_b(3, 32'h400, 1'b0);
    push_b(0, 32'h100, 1'b0);
    push_b(3, 32'h400, 1'b0);
    req_b = 4'b1001;
    drain_b("rr_wrap");
    hold_b = 0;
    tick_b(); tick_b();

    // Busy stuck high: abort after 8 ACCESS cycles with error.
    busy_cfg_b = 1000;
    push_b(2, 32'h300, 1'b1);
    tick_no_b = 0; ren_cyc_b = 0; rdy_tick_b = 0;
    req_b = 4'b0100;
    drain_b("timeout");
    chk("timeout_ren_cycles", ren_cyc_b, 8);
    chk("timeout_ready_tick", rdy_tick_b, 9);
    tick_b();
    chk("timeout_ren_dropped", ren_b, 0);

    // Normal access after a timeout carries no error.
    busy_cfg_b = 1;
    push_b(1, 32'h200, 1'b0);
    req_b = 4'b0010;
    drain_b("after_timeout");
    tick_b(); tick_b();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
